// File: rtl/store_buffer.sv
// Write-back store buffer between a CPU and a single-port memory: queues stores,
// forwards pending store data to loads, and lets load misses go ahead of queued stores.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_we,
    input  logic             cpu_re,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_rvalid,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e            r_state;
    logic [WIDTH-1:0]  r_rd_addr;
    logic [WIDTH-1:0]  r_addr [DEPTH];
    logic [WIDTH-1:0]  r_data [DEPTH];
    logic [PtrW-1:0]   r_head;
    logic [PtrW-1:0]   r_tail;
    logic [CntW-1:0]   r_count;

    logic              w_full;
    logic              w_load;
    logic              w_hit;
    logic [WIDTH-1:0]  w_fwd_data;
    logic              w_miss;
    logic              w_push;
    logic              w_pop;
    logic              w_rd_done;

    assign w_full    = (r_count == CntW'(DEPTH));
    assign w_load    = cpu_re & ~cpu_we;
    assign w_miss    = w_load & ~w_hit;
    assign w_push    = cpu_we & ~w_full;
    assign w_pop     = (r_state == StWrite) & mem_ready;
    assign w_rd_done = (r_state == StRead) & mem_ready;

    // Walk oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CntW'(i) < r_count) &&
                (r_addr[r_head + PtrW'(i)][WIDTH-1:2] == cpu_addr[WIDTH-1:2])) begin
                w_hit      = 1'b1;
                w_fwd_data = r_data[r_head + PtrW'(i)];
            end
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (r_state)
            StWrite: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr[r_head];
                mem_wdata = r_data[r_head];
            end
            StRead: begin
                mem_req  = 1'b1;
                mem_addr = r_rd_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        if (w_load && w_hit) begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = w_fwd_data;
        end else if (w_rd_done) begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = mem_rdata;
        end
        stall = (cpu_we & w_full) | (w_miss & ~w_rd_done);
    end

    // Entry storage is not cleared on reset; count==0 makes it unreachable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= cpu_addr;
                r_data[r_tail] <= cpu_wdata;
                r_tail         <= r_tail + PtrW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PtrW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_rd_addr <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_miss) begin
                        r_state   <= StRead;
                        r_rd_addr <= cpu_addr;
                    end else if (r_count != '0) begin
                        r_state <= StWrite;
                    end
                end
                StWrite: if (mem_ready) r_state <= StIdle;
                StRead:  if (mem_ready) r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-store entries (power of two, at least 2).
REQ-002 SHALL have parameter WIDTH, default 32, address and data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cpu_we  input  1  CPU store request (memwrite).
REQ-006 SHALL have port cpu_re  input  1  CPU load request.
REQ-007 SHALL have port cpu_addr  input  WIDTH  byte address (aluout); word-granular, bits [1:0] ignored.
REQ-008 SHALL have port cpu_wdata  input  WIDTH  store data (writedata).
REQ-009 SHALL have port cpu_rdata  output  WIDTH  load data (readdata).
REQ-010 SHALL have port cpu_rvalid  output  1  cpu_rdata valid this cycle.
REQ-011 SHALL have port stall  output  1  CPU holds the current instruction while high.
REQ-012 SHALL have port mem_req  output  1  memory request valid.
REQ-013 SHALL have port mem_we  output  1  1 = write, 0 = read.
REQ-014 SHALL have port mem_addr  output  WIDTH  memory address.
REQ-015 SHALL have port mem_wdata  output  WIDTH  memory write data.
REQ-016 SHALL have port mem_rdata  input  WIDTH  memory read data, valid with mem_ready.
REQ-017 SHALL have port mem_ready  input  1  completes the current request this cycle.

Function
REQ-018 SHALL hold pending stores in a circular FIFO of DEPTH {addr, data} entries, with head/tail pointers wrapping modulo DEPTH and a count from 0 to DEPTH.
REQ-019 SHALL push {cpu_addr, cpu_wdata} at the clock edge when cpu_we=1 and count<DEPTH.
REQ-020 SHALL not push when count==DEPTH; the store is blocked and stall=1.
REQ-021 SHALL treat cpu_re as absent when cpu_we and cpu_re are both high (store wins).
REQ-022 SHALL forward on a load hit: cpu_re=1 with the word address equal to any valid entry gives cpu_rdata = data of the youngest matching entry, cpu_rvalid=1 and stall=0 in the same cycle, with no memory access.
REQ-023 SHALL include the entry currently being written to memory in forwarding until it is popped.
REQ-024 SHALL implement the FSM IDLE, WRITE, READ; in IDLE, mem_req=0.
REQ-025 SHALL, in IDLE, go to READ on a load miss and latch cpu_addr; else go to WRITE if count>0; else stay in IDLE.
REQ-026 SHALL, in WRITE, drive mem_req=1, mem_we=1, mem_addr=head addr, mem_wdata=head data; on mem_ready, pop the head and go to IDLE.
REQ-027 SHALL, in READ, drive mem_req=1, mem_we=0, mem_addr=latched address; on mem_ready, set cpu_rdata=mem_rdata and cpu_rvalid=1 combinationally that cycle, then go to IDLE.
REQ-028 SHALL hold mem_addr, mem_wdata and mem_we stable while mem_req=1 and mem_ready=0; an outstanding request is never pre-empted.
REQ-029 SHALL assert stall = (cpu_we and count==DEPTH) or (cpu_re and miss and not (READ and mem_ready)).
REQ-030 SHALL make a load miss arriving during WRITE wait for that write to complete, then pass through IDLE to READ.
REQ-031 SHALL allow a push in the same cycle as a WRITE pop; count is then unchanged and both pointers advance.
REQ-032 SHALL hold cpu_rvalid=0 and cpu_rdata=0 when neither forwarding nor READ completion occurs.

Reset
REQ-033 SHALL, on reset=1 at a clock edge, set count=0, pointers=0, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stall=0 and cpu_rvalid=0.
REQ-034 SHALL discard pending stores and abandon any outstanding request on reset mid-operation; no mem_req for 1 cycle after reset deasserts.

Verification
REQ-035 SHALL verify store then forward: store 0xDEADBEEF to 0x10 with mem_ready=0, then load 0x10 -> cpu_rvalid=1, cpu_rdata=0xDEADBEEF, stall=0, no mem_req with mem_we=0.
REQ-036 SHALL verify full: with DEPTH=4 and mem_ready=0, make 5 consecutive stores -> the 5th sees stall=1 and count stays 4; after mem_ready pulses, the 5th store is accepted.
REQ-037 SHALL verify drain order: stores to 0x0, 0x4, 0x8 with data 1, 2, 3 and mem_ready=1 -> memory sees writes in order 0x0/1, 0x4/2, 0x8/3, each separated by one IDLE cycle.
REQ-038 SHALL verify a load miss during WRITE: load 0x40 (memory holds 0x55) while a write is outstanding -> stall=1 until the write completes, then READ, then cpu_rdata=0x55 with cpu_rvalid=1.
REQ-039 SHALL verify youngest-wins: stores 0xA then 0xB to 0x20, then load 0x20 -> cpu_rdata=0xB.
REQ-040 SHALL verify reset mid-WRITE: assert reset with 3 entries pending -> the next cycle has mem_req=0 and count=0, and a load to a previously stored address misses and goes to memory.
